// File: rtl/data_ram.sv
// rtl/data_ram.sv - word-organised single-port data memory, combinational read, synchronous write
module data_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  DE,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD
);

    localparam int DEPTH = 2 ** WORD_ADDR_BITS;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [WORD_ADDR_BITS-1:0] index;
    logic                      in_range;
    logic                      unused_byte_offset;

    assign index              = A[WORD_ADDR_BITS+1:2];
    assign in_range           = (A[DATA_WIDTH-1:WORD_ADDR_BITS+2] == '0);
    // Byte offset bits are deliberately dropped: every access is a whole word.
    assign unused_byte_offset = ^A[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (DE && WE && in_range) begin
            mem[index] <= WD;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign RD = (DE && in_range) ? mem[index] : '0;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - table-driven self-checking bench for data_ram
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic        DE;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks;
    int errors;

    data_ram #(
        .DATA_WIDTH    (32),
        .WORD_ADDR_BITS(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .DE   (DE),
        .WE   (WE),
        .A    (A),
        .WD   (WD),
        .RD   (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        de;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        edge_en;
        logic [31:0] exp_pre;
        logic [31:0] exp_post;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: RD=0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic add(input string n, input logic de, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic e, input logic [31:0] pre,
                       input logic [31:0] post);
        vec_t v;
        v.name = n; v.de = de; v.we = we; v.a = a; v.wd = wd;
        v.edge_en = e; v.exp_pre = pre; v.exp_post = post;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        add("rst_read",      1, 0, 32'h0000_0010, 32'h0,          0, 32'h0,          32'h0);
        add("write_dead",    1, 1, 32'h0000_0010, 32'hDEAD_BEEF,  1, 32'h0,          32'hDEAD_BEEF);
        add("read_dead",     1, 0, 32'h0000_0010, 32'h0,          0, 32'hDEAD_BEEF,  32'h0);
        add("read_lowbits",  1, 0, 32'h0000_0013, 32'h0,          0, 32'hDEAD_BEEF,  32'h0);
        add("de0_write",     0, 1, 32'h0000_0020, 32'h1234_5678,  1, 32'h0,          32'h0);
        add("de0_blocked",   1, 0, 32'h0000_0020, 32'h0,          0, 32'h0,          32'h0);
        add("de0_read",      0, 0, 32'h0000_0010, 32'h0,          0, 32'h0,          32'h0);
        add("write_1111",    1, 1, 32'h0000_0020, 32'h1111_1111,  1, 32'h0,          32'h1111_1111);
        add("rdw",           1, 1, 32'h0000_0020, 32'h2222_2222,  1, 32'h1111_1111,  32'h2222_2222);
        add("oor_write",     1, 1, 32'h0000_1000, 32'hCAFE_F00D,  1, 32'h0,          32'h0);
        add("word0_intact",  1, 0, 32'h0000_0000, 32'h0,          0, 32'h0,          32'h0);
        add("word4_intact",  1, 0, 32'h0000_0010, 32'h0,          0, 32'hDEAD_BEEF,  32'h0);
        add("top_word",      1, 1, 32'h0000_0FFC, 32'h0BAD_F00D,  1, 32'h0,          32'h0BAD_F00D);
        add("oor_high_read", 1, 0, 32'h8000_0FFC, 32'h0,          0, 32'h0,          32'h0);
        add("top_read",      1, 0, 32'h0000_0FFC, 32'h0,          0, 32'h0BAD_F00D,  32'h0);
        add("write_a5",      1, 1, 32'h0000_0004, 32'hA5A5_A5A5,  1, 32'h0,          32'hA5A5_A5A5);

        rst_n = 1'b0;
        DE    = 1'b1;
        WE    = 1'b0;
        A     = 32'h0000_0010;
        WD    = 32'h0;
        repeat (2) @(posedge clk);
        #1 check("in_reset", RD, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            DE = vecs[i].de;
            WE = vecs[i].we;
            A  = vecs[i].a;
            WD = vecs[i].wd;
            #1 check({vecs[i].name, "_pre"}, RD, vecs[i].exp_pre);
            if (vecs[i].edge_en) begin
                @(posedge clk);
                #1 check({vecs[i].name, "_post"}, RD, vecs[i].exp_post);
                WE = 1'b0;
            end
        end

        // Async reset asserted between edges clears storage immediately.
        @(negedge clk);
        DE = 1'b1; WE = 1'b0; A = 32'h0000_0004;
        #1 check("pre_async", RD, 32'hA5A5_A5A5);
        #1 rst_n = 1'b0;
        #1 check("async_clear", RD, 32'h0);
        A = 32'h0000_0010;
        #1 check("async_clear_other", RD, 32'h0);

        // Writes are ignored while reset is held.
        WE = 1'b1; WD = 32'h0000_0001;
        @(posedge clk);
        #1 check("write_in_reset", RD, 32'h0);

        // Release mid-cycle; the next edge writes normally.
        #2 rst_n = 1'b1;
        WD = 32'h0000_0077;
        #1 check("post_release_pre", RD, 32'h0);
        @(posedge clk);
        #1 check("post_release_write", RD, 32'h0000_0077);
        WE = 1'b0;
        A  = 32'h0000_0FFC;
        #1 check("top_cleared", RD, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Word-organised, single-port data memory backing the data cache in the CPU's memory stage.
- Reads are combinational, so the cache can forward data on a miss in the same cycle and refill its line on the next clock edge.
- Writes are synchronous on the rising clock edge.
- The cache instantiates this block directly and shares its enable, write-enable, address and write-data signals.

Parameters:
- DATA_WIDTH, 32, width of data words and of the address bus (A, WD, RD).
- WORD_ADDR_BITS, 10, number of word-index bits; depth = 2**WORD_ADDR_BITS words (default 1024 words / 4 KiB).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- DE  input  1  data (memory) enable; gates both read and write.
- WE  input  1  write enable; effective only when DE=1.
- A  input  DATA_WIDTH  byte address.
- WD  input  DATA_WIDTH  write data (full word).
- RD  output  DATA_WIDTH  read data (combinational).

Behaviour:
- Addressing: word index = A[WORD_ADDR_BITS+1:2]. A[1:0] is ignored; all accesses are whole-word.
- Range check: address is in range iff A[DATA_WIDTH-1:WORD_ADDR_BITS+2] == 0.
- Read:
  - RD = mem[index] when DE=1 and the address is in range.
  - RD = 0 when DE=0 or the address is out of range.
  - Purely combinational, zero latency; RD follows A, DE and memory contents within the same cycle.
- Write:
  - On posedge clk, if rst_n=1, DE=1, WE=1 and the address is in range, then mem[index] <= WD.
  - Out-of-range writes are silently dropped.
  - DE=0 blocks writes regardless of WE.
- Read-during-write to the same word:
  - Before the edge, RD shows the old contents.
  - After the edge, RD shows WD (old-data-before-edge semantics, no bypass).
- Reset:
  - rst_n=0 asynchronously clears every word to 0, independent of clk.
  - While rst_n=0, writes are ignored and RD reads 0 for any enabled in-range address.
  - Deasserting rst_n mid-cycle takes effect from the next rising edge.
- Power-up contents without reset are undefined; the bench must apply reset first.
- No handshake and no stall: every enabled access completes in the cycle it is presented.
- WE with DE=0 is legal and has no effect.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release; DE=1, A=0x0000_0010 -> RD=0x0000_0000.
- Write then read: DE=1, WE=1, A=0x0000_0010, WD=0xDEADBEEF, one edge; then WE=0 -> RD=0xDEADBEEF in the same cycle A is applied. A=0x0000_0013 (same word, low bits ignored) -> RD=0xDEADBEEF.
- Enable gating:
  - DE=0, WE=1, A=0x0000_0020, WD=0x12345678, one edge; then DE=1, WE=0, A=0x20 -> RD=0.
  - Any A with DE=0 -> RD=0.
- Read-during-write: word 0x20 holds 0x11111111; drive WE=1, WD=0x22222222 at A=0x20.
  - RD=0x11111111 before the edge.
  - RD=0x22222222 after the edge.
- Out of range: DE=1, WE=1, A=0x0000_1000 (index bits wrap to 0), WD=0xCAFEF00D, one edge.
  - RD=0 at 0x1000.
  - Word 0x0000_0000 unchanged at 0.
- Async reset mid-operation: write 0xA5A5A5A5 to A=0x4; assert rst_n=0 between clock edges -> RD at A=0x4 drops to 0 immediately, before the next edge.
